// File: rtl/pc_stack_ctrl.sv
// pc_stack_ctrl
// Control-flow sequencer that sits between the instruction decoder and the
// program counter. It keeps a hardware return-address stack for CALL/RET,
// injects a single-level interrupt, and returns from it with RETI.
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   PC_count              current PC value from pc
//   jmp_req/jmp_addr      decoded JMP and its target
//   call_req/call_addr    decoded CALL and its target
//   ret_req, reti_req     decoded RET / RETI
//   ie_set, ie_clr        EI / DI (clear wins)
//   irq                   external interrupt request, level
//   skok_pc, skok_pc_stos, adres_skok_pc, adres_skok_pc_stos, reti_int_en
//                         jump controls for pc (combinational, same-cycle)
//   int_flush             decoder must drop the instruction at PC_count
//   in_isr, gie           handler active / global interrupt enable
//   sp, stack_full, stack_empty, stack_err
//                         stack occupancy, status and sticky error flag
module pc_stack_ctrl #(
    parameter int             W       = 8,
    parameter int             DEPTH   = 8,
    parameter logic [W-1:0]   INT_VEC = 'h01
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [W-1:0]               PC_count,
    input  logic                       jmp_req,
    input  logic [W-1:0]               jmp_addr,
    input  logic                       call_req,
    input  logic [W-1:0]               call_addr,
    input  logic                       ret_req,
    input  logic                       reti_req,
    input  logic                       ie_set,
    input  logic                       ie_clr,
    input  logic                       irq,
    output logic                       skok_pc,
    output logic                       skok_pc_stos,
    output logic [W-1:0]               adres_skok_pc,
    output logic [W-1:0]               adres_skok_pc_stos,
    output logic                       reti_int_en,
    output logic                       int_flush,
    output logic                       in_isr,
    output logic                       gie,
    output logic [$clog2(DEPTH):0]     sp,
    output logic                       stack_full,
    output logic                       stack_empty,
    output logic                       stack_err
);

    localparam int AW  = $clog2(DEPTH);
    localparam int SPW = AW + 1;

    typedef enum logic {RUN = 1'b0, ISR = 1'b1} state_t;

    state_t             state_reg, state_next;
    logic [W-1:0]       mem [DEPTH];
    logic [SPW-1:0]     sp_reg;
    logic               gie_reg;
    logic               irq_pend_reg;
    logic               stack_err_reg;

    logic [SPW-1:0]     sp_dec;
    logic [AW-1:0]      top_idx;
    logic               is_full;
    logic               is_empty;
    logic               push;
    logic               pop;
    logic               err_set;
    logic               take_int;

    assign sp_dec   = sp_reg - SPW'(1);
    assign top_idx  = sp_dec[AW-1:0];
    assign is_full  = (sp_reg == SPW'(DEPTH));
    assign is_empty = (sp_reg == '0);

    assign in_isr      = (state_reg == ISR);
    assign gie         = gie_reg;
    assign sp          = sp_reg;
    assign stack_full  = is_full;
    assign stack_empty = is_empty;
    assign stack_err   = stack_err_reg;

    // Decision logic: at most one action per cycle, RETI > RET > CALL > JMP
    // > interrupt entry. A faulting request still owns the cycle, so lower
    // priority requests are not promoted in its place.
    always_comb begin
        skok_pc            = 1'b0;
        skok_pc_stos       = 1'b0;
        adres_skok_pc      = '0;
        adres_skok_pc_stos = '0;
        reti_int_en        = 1'b0;
        int_flush          = 1'b0;
        push               = 1'b0;
        pop                = 1'b0;
        err_set            = 1'b0;
        take_int           = 1'b0;
        state_next         = state_reg;

        if (!rst) begin
            adres_skok_pc_stos = is_empty ? '0 : mem[top_idx];
            if (reti_req) begin
                // Underflowing RETI still leaves the handler.
                state_next = RUN;
                if (!is_empty) begin
                    skok_pc      = 1'b1;
                    skok_pc_stos = 1'b1;
                    reti_int_en  = 1'b1;
                    pop          = 1'b1;
                end else begin
                    err_set = 1'b1;
                end
            end else if (ret_req) begin
                if (!is_empty) begin
                    skok_pc      = 1'b1;
                    skok_pc_stos = 1'b1;
                    pop          = 1'b1;
                end else begin
                    err_set = 1'b1;
                end
            end else if (call_req) begin
                if (!is_full) begin
                    skok_pc       = 1'b1;
                    adres_skok_pc = call_addr;
                    push          = 1'b1;
                end else begin
                    err_set = 1'b1;
                end
            end else if (jmp_req) begin
                skok_pc       = 1'b1;
                adres_skok_pc = jmp_addr;
            end else if (irq_pend_reg && gie_reg && (state_reg == RUN) && !is_full) begin
                // The instruction at PC_count is squashed and its address
                // saved, so it re-executes after RETI (which skips the +1).
                take_int      = 1'b1;
                skok_pc       = 1'b1;
                adres_skok_pc = INT_VEC;
                int_flush     = 1'b1;
                push          = 1'b1;
                state_next    = ISR;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= RUN;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sp_reg        <= '0;
            gie_reg       <= 1'b0;
            irq_pend_reg  <= 1'b0;
            stack_err_reg <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[sp_reg[AW-1:0]] <= PC_count;
                sp_reg              <= sp_reg + SPW'(1);
            end else if (pop) begin
                sp_reg <= sp_dec;
            end
            if (err_set) begin
                stack_err_reg <= 1'b1;
            end
            if (ie_clr) begin
                gie_reg <= 1'b0;
            end else if (ie_set) begin
                gie_reg <= 1'b1;
            end
            // Entry beats a simultaneous irq; a still-high level re-pends
            // on the following cycle.
            if (take_int) begin
                irq_pend_reg <= 1'b0;
            end else if (irq) begin
                irq_pend_reg <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pc_stack_ctrl.sv
// Self-checking bench for pc_stack_ctrl: a stimulus table plus hand-written
// overflow / reset-in-ISR sequences; expected outputs are queued when a
// vector is driven and compared mid-cycle by a scoreboard process.
module tb_pc_stack_ctrl;

    localparam bit N = 1'b0;
    localparam bit Y = 1'b1;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] PC_count, jmp_addr, call_addr;
    logic       jmp_req, call_req, ret_req, reti_req, ie_set, ie_clr, irq;
    logic       skok_pc, skok_pc_stos, reti_int_en, int_flush, in_isr, gie;
    logic [7:0] adres_skok_pc, adres_skok_pc_stos;
    logic [3:0] sp;
    logic       stack_full, stack_empty, stack_err;

    always #5 clk = ~clk;

    pc_stack_ctrl #(.W(8), .DEPTH(8), .INT_VEC(8'h01)) dut (
        .clk(clk), .rst(rst), .PC_count(PC_count),
        .jmp_req(jmp_req), .jmp_addr(jmp_addr),
        .call_req(call_req), .call_addr(call_addr),
        .ret_req(ret_req), .reti_req(reti_req),
        .ie_set(ie_set), .ie_clr(ie_clr), .irq(irq),
        .skok_pc(skok_pc), .skok_pc_stos(skok_pc_stos),
        .adres_skok_pc(adres_skok_pc), .adres_skok_pc_stos(adres_skok_pc_stos),
        .reti_int_en(reti_int_en), .int_flush(int_flush),
        .in_isr(in_isr), .gie(gie), .sp(sp),
        .stack_full(stack_full), .stack_empty(stack_empty), .stack_err(stack_err)
    );

    typedef struct packed {
        bit       rst;
        bit [7:0] pc;
        bit       jmp;
        bit [7:0] ja;
        bit       call;
        bit [7:0] ca;
        bit       ret;
        bit       reti;
        bit       ies;
        bit       iec;
        bit       irq;
    } in_t;

    typedef struct packed {
        bit       skok;
        bit       stos;
        bit [7:0] addr;
        bit [7:0] astos;
        bit       reti_en;
        bit       flush;
        bit       isr;
        bit       gie;
        bit [3:0] sp;
        bit       full;
        bit       empty;
        bit       err;
    } exp_t;

    typedef struct {
        in_t   i;
        exp_t  e;
        string name;
    } vec_t;

    vec_t  tbl[$];
    exp_t  exp_q[$];
    string name_q[$];
    int    checks = 0;
    int    errors = 0;

    function automatic in_t mi(bit r, bit [7:0] pc, bit jmp, bit [7:0] ja, bit call,
                               bit [7:0] ca, bit ret, bit reti, bit ies, bit iec, bit irq_v);
        in_t v;
        v.rst = r;  v.pc = pc;  v.jmp = jmp;   v.ja = ja;   v.call = call; v.ca = ca;
        v.ret = ret; v.reti = reti; v.ies = ies; v.iec = iec; v.irq = irq_v;
        return v;
    endfunction

    // Expected outputs; full/empty follow directly from the expected sp.
    function automatic exp_t me(bit skok, bit stos, bit [7:0] addr, bit [7:0] astos,
                                bit reti_en, bit flush, bit isr, bit g, bit [3:0] spv, bit err);
        exp_t v;
        v.skok = skok; v.stos = stos; v.addr = addr; v.astos = astos;
        v.reti_en = reti_en; v.flush = flush; v.isr = isr; v.gie = g;
        v.sp = spv; v.full = (spv == 4'd8); v.empty = (spv == 4'd0); v.err = err;
        return v;
    endfunction

    task automatic add(input in_t i, input exp_t e, input string nm);
        vec_t v;
        v.i = i; v.e = e; v.name = nm;
        tbl.push_back(v);
    endtask

    task automatic drive(input in_t i);
        rst = i.rst; PC_count = i.pc; jmp_req = i.jmp; jmp_addr = i.ja;
        call_req = i.call; call_addr = i.ca; ret_req = i.ret; reti_req = i.reti;
        ie_set = i.ies; ie_clr = i.iec; irq = i.irq;
    endtask

    task automatic apply(input in_t i, input exp_t e, input string nm);
        @(posedge clk);
        #1;
        drive(i);
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    // Scoreboard: compare mid-cycle, after inputs settle and before the edge.
    exp_t  sb_exp, sb_act;
    string sb_name;
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            sb_exp  = exp_q.pop_front();
            sb_name = name_q.pop_front();
            sb_act  = '{skok_pc, skok_pc_stos, adres_skok_pc, adres_skok_pc_stos,
                        reti_int_en, int_flush, in_isr, gie, sp,
                        stack_full, stack_empty, stack_err};
            checks++;
            if (sb_act !== sb_exp) begin
                errors++;
                $display("FAIL %s: got %h expected %h (skok,stos,addr,astos,reti,flush,isr,gie,sp,full,empty,err)",
                         sb_name, sb_act, sb_exp);
            end else begin
                $display("ok   %s: %h", sb_name, sb_act);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Basic CALL/RET, interrupt entry/RETI, blocking, errors, priority.
        add(mi(Y,8'h10,N,8'h00,Y,8'h40,N,N,N,N,N), me(N,N,8'h00,8'h00,N,N,N,N,4'd0,N), "rst_forces_idle");
        add(mi(N,8'h10,N,8'h00,Y,8'h40,N,N,N,N,N), me(Y,N,8'h40,8'h00,N,N,N,N,4'd0,N), "call_40");
        add(mi(N,8'h40,N,8'h00,N,8'h00,Y,N,N,N,N), me(Y,Y,8'h00,8'h10,N,N,N,N,4'd1,N), "ret_to_10");
        add(mi(N,8'h11,N,8'h00,N,8'h00,N,N,Y,N,N), me(N,N,8'h00,8'h00,N,N,N,N,4'd0,N), "ei");
        add(mi(N,8'h22,N,8'h00,N,8'h00,N,N,N,N,Y), me(N,N,8'h00,8'h00,N,N,N,Y,4'd0,N), "irq_pend_delay");
        add(mi(N,8'h22,N,8'h00,N,8'h00,N,N,N,N,N), me(Y,N,8'h01,8'h00,N,Y,N,Y,4'd0,N), "int_entry");
        add(mi(N,8'h01,N,8'h00,N,8'h00,N,N,N,N,Y), me(N,N,8'h00,8'h22,N,N,Y,Y,4'd1,N), "in_isr_irq");
        add(mi(N,8'h02,N,8'h00,N,8'h00,N,N,N,N,N), me(N,N,8'h00,8'h22,N,N,Y,Y,4'd1,N), "no_nest");
        add(mi(N,8'h03,N,8'h00,N,8'h00,N,Y,N,N,N), me(Y,Y,8'h00,8'h22,Y,N,Y,Y,4'd1,N), "reti");
        add(mi(N,8'h22,N,8'h00,Y,8'h50,N,N,N,N,N), me(Y,N,8'h50,8'h00,N,N,N,Y,4'd0,N), "call_blocks_int");
        add(mi(N,8'h50,N,8'h00,N,8'h00,N,N,N,N,N), me(Y,N,8'h01,8'h22,N,Y,N,Y,4'd1,N), "int_after_call");
        add(mi(N,8'h01,N,8'h00,N,8'h00,N,Y,N,N,N), me(Y,Y,8'h00,8'h50,Y,N,Y,Y,4'd2,N), "reti_to_50");
        add(mi(N,8'h51,N,8'h00,N,8'h00,Y,N,N,N,N), me(Y,Y,8'h00,8'h22,N,N,N,Y,4'd1,N), "ret_to_22");
        add(mi(N,8'h23,N,8'h00,N,8'h00,N,N,Y,Y,Y), me(N,N,8'h00,8'h00,N,N,N,Y,4'd0,N), "di_beats_ei");
        add(mi(N,8'h24,N,8'h00,N,8'h00,N,N,N,N,N), me(N,N,8'h00,8'h00,N,N,N,N,4'd0,N), "gie0_blocks");
        add(mi(N,8'h25,N,8'h00,N,8'h00,Y,N,N,N,N), me(N,N,8'h00,8'h00,N,N,N,N,4'd0,N), "ret_underflow");
        add(mi(N,8'h26,Y,8'h80,N,8'h00,N,N,N,N,N), me(Y,N,8'h80,8'h00,N,N,N,N,4'd0,Y), "jmp_err_sticky");
        add(mi(N,8'h30,N,8'h00,Y,8'h60,N,N,N,N,N), me(Y,N,8'h60,8'h00,N,N,N,N,4'd0,Y), "call_60");
        add(mi(N,8'h60,Y,8'h90,Y,8'h70,Y,N,N,N,N), me(Y,Y,8'h00,8'h30,N,N,N,N,4'd1,Y), "ret_wins_prio");
        add(mi(N,8'h31,N,8'h00,N,8'h00,N,Y,N,N,N), me(N,N,8'h00,8'h00,N,N,N,N,4'd0,Y), "reti_underflow");
        add(mi(Y,8'h00,N,8'h00,N,8'h00,N,N,N,N,N), me(N,N,8'h00,8'h00,N,N,N,N,4'd0,Y), "rst_assert");
        add(mi(N,8'h00,N,8'h00,N,8'h00,N,N,N,N,N), me(N,N,8'h00,8'h00,N,N,N,N,4'd0,N), "rst_clears_err");

        drive(mi(Y,8'h00,N,8'h00,N,8'h00,N,N,N,N,N));
        repeat (2) @(posedge clk);

        foreach (tbl[k]) begin
            apply(tbl[k].i, tbl[k].e, tbl[k].name);
        end

        // Overflow: fill the stack, then a 9th CALL with an irq pending.
        apply(mi(N,8'h00,N,8'h00,N,8'h00,N,N,Y,N,N), me(N,N,8'h00,8'h00,N,N,N,N,4'd0,N), "ovf_ei");
        for (int k = 0; k < 8; k++) begin
            apply(mi(N,8'(k),N,8'h00,Y,8'(8'h80 + k),N,N,N,N,N),
                  me(Y,N,8'(8'h80 + k),(k == 0) ? 8'h00 : 8'(k - 1),N,N,N,Y,4'(k),N),
                  $sformatf("fill_call_%0d", k));
        end
        apply(mi(N,8'h08,N,8'h00,Y,8'h88,N,N,N,N,Y), me(N,N,8'h00,8'h07,N,N,N,Y,4'd8,N), "call_overflow");
        apply(mi(N,8'h09,N,8'h00,N,8'h00,N,N,N,N,N), me(N,N,8'h00,8'h07,N,N,N,Y,4'd8,Y), "int_held_full");
        apply(mi(N,8'h09,N,8'h00,N,8'h00,N,Y,N,N,N), me(Y,Y,8'h00,8'h07,Y,N,N,Y,4'd8,Y), "reti_in_run");
        apply(mi(N,8'h07,N,8'h00,N,8'h00,N,N,N,N,N), me(Y,N,8'h01,8'h06,N,Y,N,Y,4'd7,Y), "held_int_taken");
        apply(mi(N,8'h01,N,8'h00,N,8'h00,N,N,N,N,Y), me(N,N,8'h00,8'h07,N,N,Y,Y,4'd8,Y), "isr_full");
        // Reset while in the handler with a pending irq.
        apply(mi(Y,8'h02,N,8'h00,N,8'h00,N,N,N,N,N), me(N,N,8'h00,8'h00,N,N,Y,Y,4'd8,Y), "rst_in_isr");
        apply(mi(N,8'h00,N,8'h00,N,8'h00,N,N,Y,N,N), me(N,N,8'h00,8'h00,N,N,N,N,4'd0,N), "after_rst");
        apply(mi(N,8'h00,N,8'h00,N,8'h00,N,N,N,N,N), me(N,N,8'h00,8'h00,N,N,N,Y,4'd0,N), "pend_lost");

        @(posedge clk);
        #1;
        drive(mi(N,8'h00,N,8'h00,N,8'h00,N,N,N,N,N));
        repeat (3) @(negedge clk);
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d queued expectations, required 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_stack_ctrl.md
# pc_stack_ctrl

Control-flow sequencer that drives the jump inputs of the program counter `pc` (`skok_pc`, `skok_pc_stos`, `adres_skok_pc`, `adres_skok_pc_stos`, `reti_int_en`). It holds a hardware return-address stack for CALL/RET, injects a single-level interrupt, and returns from it with RETI. It sits between the instruction decoder and `pc`.

## Interface
- `W`, 8: address width, equal to `pc` W.
- `DEPTH`, 8: return-stack entries (power of 2, ≥2).
- `INT_VEC`, 8'h01: interrupt handler address.

- `clk` in 1: clock.
- `rst` in 1: synchronous, active-high reset.
- `PC_count` in W: current PC value from `pc`.
- `jmp_req` in 1, `jmp_addr` in W: decoded JMP and its target.
- `call_req` in 1, `call_addr` in W: decoded CALL and its target.
- `ret_req` in 1: decoded RET.
- `reti_req` in 1: decoded RETI.
- `ie_set` in 1, `ie_clr` in 1: EI and DI instructions.
- `irq` in 1: external interrupt request, level.
- `skok_pc` out 1, `skok_pc_stos` out 1, `adres_skok_pc` out W, `adres_skok_pc_stos` out W, `reti_int_en` out 1: drive `pc`.
- `int_flush` out 1: decoder must discard the instruction at `PC_count` this cycle.
- `in_isr` out 1: handler active.
- `gie` out 1: global interrupt enable.
- `sp` out $clog2(DEPTH)+1: stack occupancy.
- `stack_full` out 1, `stack_empty` out 1.
- `stack_err` out 1: sticky overflow/underflow flag.

## Operation
- Registered state: stack `mem[DEPTH]`, `sp`, `gie`, `irq_pend`, `stack_err`, and FSM {RUN, ISR}. `in_isr` = (state==ISR).
- `adres_skok_pc_stos` = `mem[sp-1]` when `sp`>0, else 0. `stack_full` = (`sp`==DEPTH). `stack_empty` = (`sp`==0).
- One action per cycle, in priority order: RETI > RET > CALL > JMP > interrupt entry > none.
- **RETI**, sp>0: `skok_pc`=`skok_pc_stos`=`reti_int_en`=1. Pop. State goes to RUN. `pc` resumes at the popped address with no +1.
- **RET**, sp>0: `skok_pc`=`skok_pc_stos`=1, `reti_int_en`=0. Pop. `pc` resumes at the popped address +1.
- **CALL**, not full: `skok_pc`=1, `adres_skok_pc`=`call_addr`. Push `PC_count`.
- **JMP**: `skok_pc`=1, `adres_skok_pc`=`jmp_addr`. Stack unchanged.
- **Interrupt entry**: taken when `irq_pend` & `gie` & state==RUN & no request & not full.
  - Outputs: `skok_pc`=1, `adres_skok_pc`=INT_VEC, `int_flush`=1.
  - Push `PC_count` (the squashed instruction re-executes after RETI).
  - Clear `irq_pend`; state goes to ISR.
- `irq_pend`: set on any cycle with `irq`=1; cleared only on entry. A set in the same cycle as entry loses, so pend reloads next cycle if `irq` is still high.
- `gie`: `ie_clr` wins over `ie_set`. It is unaffected by entry and RETI, because nesting is blocked by the ISR state.
- **Errors** (set `stack_err`, cleared only by `rst`). The faulting request produces no jump and no stack change; `pc` just increments.
  - CALL when full: overflow.
  - RET or RETI when empty: underflow.
  - RETI underflow still forces state to RUN.
- Interrupt while full: not taken, stays pending, no error.
- RETI while in RUN with sp>0: pops like RET but without +1; no error.

## Timing
- Jump outputs are combinational from the current requests and registered state. `pc` loads on the same `clk` edge that updates `sp`, `mem`, and the FSM, giving zero-cycle decision latency.
- Reset values: `sp`=0, `mem`=0, `gie`=0, `irq_pend`=0, `stack_err`=0, state=RUN. All jump outputs and `int_flush` are 0 while `rst`=1.
- Reset in ISR or mid-sequence: everything above is restored at the next edge; any pending interrupt is lost.
- `irq` to first possible entry: 1 cycle (the pend register).
- Back-to-back CALL/RET on consecutive cycles is supported. Push and pop never occur in the same cycle.
- `sp` never wraps: it saturates at 0 and DEPTH through the error rules.

## Test plan
- **Reset, then CALL/RET.**
  - Stimulus: `PC_count`=8'h10, `call_req`=1, `call_addr`=8'h40.
  - Required: `skok_pc`=1, `adres_skok_pc`=8'h40, sp becomes 1, top=8'h10.
  - Next, `ret_req`=1: `skok_pc_stos`=1, `reti_int_en`=0, `adres_skok_pc_stos`=8'h10, sp becomes 0.
- **Interrupt entry and RETI.**
  - Stimulus: `ie_set`, then `irq`=1 with `PC_count`=8'h22.
  - Required, one cycle later: `int_flush`=1, `adres_skok_pc`=8'h01, `in_isr`=1, top=8'h22.
  - Then, `reti_req`: `reti_int_en`=1, `adres_skok_pc_stos`=8'h22, `in_isr`=0.
- **Interrupt blocking.** Required: no entry while `gie`=0, while in ISR, or in a cycle with `call_req`=1. The entry is taken on the first cycle with no request.
- **Overflow.**
  - Stimulus: 8 CALLs, then a 9th CALL.
  - Required: the 9th gives `skok_pc`=0, `stack_err`=1, sp=8, `stack_full`=1.
  - A pending irq is held and not taken while full.
- **Underflow.** Stimulus: RET with sp=0. Required: `skok_pc`=0, `stack_err`=1, sp=0.
- **Priority and reset.**
  - Stimulus: `ret_req`=`call_req`=`jmp_req`=1 together. Required: RET wins.
  - Stimulus: `rst` asserted in ISR with sp=3. Required: next cycle sp=0, `in_isr`=0, `gie`=0, `stack_err`=0.
